temporizador_bcd: RTL and testbench

TEMPORIZADOR_BCD -- requirements
Module: temporizador_bcd

---
 rtl/temporizador_bcd_pkg.sv | 22 ++
 rtl/digito_bcd_dec.sv | 34 +++
 rtl/temporizador_bcd.sv | 136 +++++++++++++
 tb/tb_temporizador_bcd.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/temporizador_bcd_pkg.sv
// Shared constants for the BCD countdown timer: FSM state encodings,
// digit limits and a small BCD validity helper.
package temporizador_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Largest value each digit position takes when it wraps on a borrow
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] DEZ_MAX = 4'd5;

    localparam int MOD_UNI = int'(BCD_MAX) + 1;
    localparam int MOD_DEZ = int'(DEZ_MAX) + 1;

    function automatic logic is_bcd(input logic [3:0] value);
        return value <= BCD_MAX;
    endfunction

endpackage

// File: rtl/digito_bcd_dec.sv
// One BCD digit of the countdown: parallel load from the keypad shift chain,
// or step down by one when a borrow reaches it, wrapping 0 -> MODULUS-1.
module digito_bcd_dec
    import temporizador_bcd_pkg::*;
#(
    parameter int MODULUS = MOD_UNI
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] shift_in,
    input  logic       dec,
    input  logic       borrow_in,
    output logic       borrow_out,
    output logic [3:0] value
);

    localparam logic [3:0] TOP = 4'(MODULUS - 1);

    // Borrow ripples on only when this digit is already at zero
    assign borrow_out = borrow_in & (value == 4'd0);

    // Digit register: load takes priority, decrement only when borrowed from
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 4'd0;
        end else if (load) begin
            value <= shift_in;
        end else if (dec && borrow_in) begin
            value <= (value == 4'd0) ? TOP : value - 4'd1;
        end
    end

endmodule

// File: rtl/temporizador_bcd.sv
// Kitchen-style BCD countdown timer (M:SS). Digits are keyed in by shifting
// left from the keypad while idle, then counted down one second per
// pgt_1Hz rising edge while enablen is held low.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   IDLE    | entry / paused; keypad loads accepted
//   RUN     | counting down on each 1 Hz tick
//   DONE    | reached 0:00; waits for enablen release
module temporizador_bcd
    import temporizador_bcd_pkg::*;
(
    input  logic       Hz_100_clock,
    input  logic       clearn,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       enablen,
    output logic [3:0] seg_uni,
    output logic [3:0] seg_dez,
    output logic [3:0] min_uni,
    output logic       zero,
    output logic       running
);

    state_t state;
    state_t state_next;

    logic loadn_prev;
    logic pgt_prev;
    logic load_ev;
    logic tick_ev;
    logic load_do;
    logic dec_do;
    logic last_second;
    logic borrow_uni;
    logic borrow_dez;
    logic borrow_min;

    // Edge-detect registers; reset to 1 so a pin already low/high at release
    // is treated as "no tick" and a key already held counts as a fresh press
    always_ff @(posedge Hz_100_clock or negedge clearn) begin
        if (!clearn) begin
            loadn_prev <= 1'b1;
            pgt_prev   <= 1'b1;
        end else begin
            loadn_prev <= loadn;
            pgt_prev   <= pgt_1Hz;
        end
    end

    assign load_ev = loadn_prev & ~loadn;
    assign tick_ev = ~pgt_prev & pgt_1Hz;

    // The units digit always requests a borrow, so the borrow out of the
    // minutes digit is high exactly when every digit is zero.
    assign zero = borrow_min;

    assign last_second = (min_uni == 4'd0) && (seg_dez == 4'd0) && (seg_uni == 4'd1);

    digito_bcd_dec #(.MODULUS(MOD_UNI)) u_seg_uni (
        .clk        (Hz_100_clock),
        .rst_n      (clearn),
        .load       (load_do),
        .shift_in   (D),
        .dec        (dec_do),
        .borrow_in  (1'b1),
        .borrow_out (borrow_uni),
        .value      (seg_uni)
    );

    digito_bcd_dec #(.MODULUS(MOD_DEZ)) u_seg_dez (
        .clk        (Hz_100_clock),
        .rst_n      (clearn),
        .load       (load_do),
        .shift_in   (seg_uni),
        .dec        (dec_do),
        .borrow_in  (borrow_uni),
        .borrow_out (borrow_dez),
        .value      (seg_dez)
    );

    digito_bcd_dec #(.MODULUS(MOD_UNI)) u_min_uni (
        .clk        (Hz_100_clock),
        .rst_n      (clearn),
        .load       (load_do),
        .shift_in   (seg_dez),
        .dec        (dec_do),
        .borrow_in  (borrow_dez),
        .borrow_out (borrow_min),
        .value      (min_uni)
    );

    // State register
    always_ff @(posedge Hz_100_clock or negedge clearn) begin
        if (!clearn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an accepted key press defers the start decision by a
    // cycle so it is taken on the freshly loaded count
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!load_do && !enablen && !zero) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (enablen) begin
                    state_next = ST_IDLE;
                end else if (tick_ev && last_second) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (enablen) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs and datapath strobes; pause beats a coincident tick
    always_comb begin
        running = (state == ST_RUN);
        load_do = (state == ST_IDLE) && load_ev && is_bcd(D);
        dec_do  = (state == ST_RUN) && !enablen && tick_ev && !zero;
    end

endmodule

// File: tb/tb_temporizador_bcd.sv
// Bench for the BCD countdown timer: keypad vector table, directed corner
// sequences, and a randomized run against a digit-field arithmetic model.
module tb_temporizador_bcd;

    logic       clk = 1'b0;
    logic       clearn = 1'b0;
    logic [3:0] D = 4'd0;
    logic       loadn = 1'b1;
    logic       pgt = 1'b0;
    logic       enablen = 1'b1;
    logic [3:0] seg_uni;
    logic [3:0] seg_dez;
    logic [3:0] min_uni;
    logic       zero;
    logic       running;

    int n_pass = 0;
    int n_total = 0;

    temporizador_bcd dut (
        .Hz_100_clock (clk),
        .clearn       (clearn),
        .D            (D),
        .loadn        (loadn),
        .pgt_1Hz      (pgt),
        .enablen      (enablen),
        .seg_uni      (seg_uni),
        .seg_dez      (seg_dez),
        .min_uni      (min_uni),
        .zero         (zero),
        .running      (running)
    );

    always #5 clk = ~clk;

    // Reference model: minutes as an integer, seconds as one 0..99 integer
    typedef struct {
        int mm;
        int tt;
        int mode;     // 0 idle, 1 counting, 2 finished
        bit lprev;
        bit pprev;
    } mstate_t;

    mstate_t ms;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.mm = 0; r.tt = 0; r.mode = 0; r.lprev = 1'b1; r.pprev = 1'b1;
        return r;
    endfunction

    function automatic mstate_t model_step(mstate_t s, bit ln, bit pg, bit en, int d);
        mstate_t n = s;
        bit lev = s.lprev && !ln;
        bit tev = !s.pprev && pg;
        bit z = (s.mm == 0) && (s.tt == 0);
        case (s.mode)
            0: begin
                if (lev && d <= 9) begin
                    n.mm = s.tt / 10;
                    n.tt = (s.tt % 10) * 10 + d;
                end else if (!en && !z) begin
                    n.mode = 1;
                end
            end
            1: begin
                if (en) begin
                    n.mode = 0;
                end else if (tev && !z) begin
                    if (s.tt > 0) begin
                        n.tt = s.tt - 1;
                    end else begin
                        n.tt = 59;
                        n.mm = s.mm - 1;
                    end
                    if (n.mm == 0 && n.tt == 0) n.mode = 2;
                end
            end
            default: begin
                if (en) n.mode = 0;
            end
        endcase
        n.lprev = ln;
        n.pprev = pg;
        return n;
    endfunction

    always @(posedge clk or negedge clearn) begin
        if (!clearn) ms <= model_reset();
        else         ms <= model_step(ms, loadn, pgt, enablen, int'(D));
    end

    function automatic logic [11:0] cnt();
        return {min_uni, seg_dez, seg_uni};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clearn = 1'b0; loadn = 1'b1; pgt = 1'b0; enablen = 1'b1; D = 4'd0;
        @(negedge clk);
        clearn = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d, input int hold);
        @(negedge clk);
        D = d; loadn = 1'b0;
        repeat (hold) @(negedge clk);
        loadn = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        pgt = 1'b1;
        @(negedge clk);
        pgt = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  d;
        int          hold;
        logic [11:0] exp;
    } key_vec_t;

    key_vec_t kv[5];

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        kv[0] = '{4'd1,  5,  12'h001};
        kv[1] = '{4'd3,  5,  12'h013};
        kv[2] = '{4'd0,  5,  12'h130};
        kv[3] = '{4'd7,  50, 12'h307};
        kv[4] = '{4'hC,  5,  12'h307};

        // Reset state while clearn is still low
        #2;
        check("reset_cnt", 32'(cnt()), 32'h000);
        check("reset_zero", 32'(zero), 32'd1);
        check("reset_running", 32'(running), 32'd0);
        @(negedge clk);
        clearn = 1'b1;
        @(negedge clk);

        // Keypad table: shift entry, single shift on long hold, non-BCD ignored
        for (int i = 0; i < 5; i++) begin
            press(kv[i].d, kv[i].hold);
            check($sformatf("key_%0d", i), 32'(cnt()), 32'(kv[i].exp));
        end

        // Full countdown 1:00 -> 0:00, DONE behaviour
        do_reset();
        press(4'd1, 3); press(4'd0, 3); press(4'd0, 3);
        check("a_loaded", 32'(cnt()), 32'h100);
        @(negedge clk); enablen = 1'b0;
        @(negedge clk);
        check("a_running", 32'(running), 32'd1);
        tick();
        check("a_first_tick", 32'(cnt()), 32'h059);
        repeat (58) tick();
        check("a_last_second", 32'(cnt()), 32'h001);
        tick();
        check("a_end_cnt", 32'(cnt()), 32'h000);
        check("a_end_zero", 32'(zero), 32'd1);
        check("a_end_running", 32'(running), 32'd0);
        tick();
        check("a_no_wrap", 32'(cnt()), 32'h000);
        press(4'd4, 3);
        check("a_done_load_ignored", 32'(cnt()), 32'h000);
        @(negedge clk); enablen = 1'b1;
        @(negedge clk);
        check("a_idle_running", 32'(running), 32'd0);

        // Pause, pause coincident with tick, resume, load in RUN
        do_reset();
        press(4'd0, 3); press(4'd5, 3);
        check("b_loaded", 32'(cnt()), 32'h005);
        @(negedge clk); enablen = 1'b0;
        @(negedge clk);
        check("b_running", 32'(running), 32'd1);
        enablen = 1'b1; pgt = 1'b1;
        @(negedge clk);
        check("b_pause_wins_cnt", 32'(cnt()), 32'h005);
        check("b_pause_running", 32'(running), 32'd0);
        pgt = 1'b0;
        repeat (3) tick();
        check("b_paused_cnt", 32'(cnt()), 32'h005);
        @(negedge clk); enablen = 1'b0;
        @(negedge clk);
        check("b_resume_running", 32'(running), 32'd1);
        tick();
        check("b_resume_tick", 32'(cnt()), 32'h004);
        press(4'd8, 5);
        check("b_run_load_ignored", 32'(cnt()), 32'h004);

        // Reset mid-run, pgt high across release
        do_reset();
        press(4'd2, 3); press(4'd0, 3); press(4'd0, 3);
        @(negedge clk); enablen = 1'b0;
        repeat (10) tick();
        check("c_after_10", 32'(cnt()), 32'h150);
        @(posedge clk);
        #2;
        pgt = 1'b1; clearn = 1'b0;
        #1;
        check("c_async_cnt", 32'(cnt()), 32'h000);
        check("c_async_zero", 32'(zero), 32'd1);
        check("c_async_running", 32'(running), 32'd0);
        @(negedge clk); clearn = 1'b1;
        repeat (2) @(negedge clk);
        check("c_release_cnt", 32'(cnt()), 32'h000);
        enablen = 1'b1;
        press(4'd5, 3);
        @(negedge clk); enablen = 1'b0;
        repeat (3) @(negedge clk);
        check("c_no_false_tick_cnt", 32'(cnt()), 32'h005);
        check("c_no_false_tick_run", 32'(running), 32'd1);
        pgt = 1'b0;
        tick();
        check("c_genuine_tick", 32'(cnt()), 32'h004);

        // Zero count cannot start; load defers start by one cycle
        do_reset();
        @(negedge clk); enablen = 1'b0;
        repeat (3) @(negedge clk);
        check("d_zero_stays_idle", 32'(running), 32'd0);
        D = 4'd9; loadn = 1'b0;
        @(negedge clk);
        check("d_load_cnt", 32'(cnt()), 32'h009);
        check("d_load_cycle_idle", 32'(running), 32'd0);
        @(negedge clk);
        check("d_next_cycle_run", 32'(running), 32'd1);
        loadn = 1'b1;

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [13:0] exp_v;
            @(negedge clk);
            exp_v = {4'(ms.mm), 4'(ms.tt / 10), 4'(ms.tt % 10),
                     (ms.mm == 0 && ms.tt == 0), (ms.mode == 1)};
            check("random", 32'({min_uni, seg_dez, seg_uni, zero, running}), 32'(exp_v));
            clearn = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) loadn = ~loadn;
            D = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) pgt = ~pgt;
            if ($urandom_range(0, 15) == 0) enablen = ~enablen;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
